// File: rtl/mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with one transaction in flight.
// Simultaneous requests are granted round-robin.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_rdata,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_rdata,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp_valid,
    output logic          mem_resp_ready,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    grant
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IFU  = 2'b01;
    localparam logic [1:0] OWN_LSU  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic          last_lsu_q, last_lsu_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wmask_q, wmask_d;

    logic          ifu_win;
    logic          lsu_win;

    // Acceptance is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        ifu_win = 1'b0;
        lsu_win = 1'b0;
        if (rst && (state_q == ST_IDLE)) begin
            if (ifu_req_valid && lsu_req_valid) begin
                ifu_win = last_lsu_q;
                lsu_win = !last_lsu_q;
            end else begin
                ifu_win = ifu_req_valid;
                lsu_win = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = ifu_win;
    assign lsu_req_ready = lsu_win;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_lsu_d = last_lsu_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (ifu_win) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWN_IFU;
                    state_d = ST_REQ;
                end else if (lsu_win) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    owner_d = OWN_LSU;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_resp_valid && mem_resp_ready) begin
                    last_lsu_d = (owner_q == OWN_LSU);
                    owner_d    = OWN_NONE;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            last_lsu_q <= 1'b1;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_lsu_q <= last_lsu_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign grant         = owner_q;

    // Response steering: bit 0 is the IFU, bit 1 the LSU, matching the owner encoding.
    logic [1:0]    resp_own;
    logic [1:0]    m_resp_ready;
    logic [1:0]    m_resp_valid;
    logic [DW-1:0] m_rdata [2];

    assign m_resp_ready = {lsu_resp_ready, ifu_resp_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_own[gi]     = (state_q == ST_RESP) && owner_q[gi];
            assign m_resp_valid[gi] = resp_own[gi] && mem_resp_valid;
            assign m_rdata[gi]      = resp_own[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign mem_resp_ready = |(resp_own & m_resp_ready);
    assign ifu_resp_valid = m_resp_valid[0];
    assign ifu_rdata      = m_rdata[0];
    assign lsu_resp_valid = m_resp_valid[1];
    assign lsu_rdata      = m_rdata[1];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter for the multicycle core: shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (data load/store). Sits between those two units and the memory slave. Every port uses a valid/ready request channel plus a valid/ready response channel. One transaction is in flight at a time; simultaneous requests are granted round-robin.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1: IFU request handshake
- `ifu_addr` in AW: fetch address
- `ifu_resp_valid` out 1 / `ifu_resp_ready` in 1: IFU response handshake
- `ifu_rdata` out DW: fetched word
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1: LSU request handshake
- `lsu_addr` in AW, `lsu_wen` in 1, `lsu_wdata` in DW, `lsu_wmask` in 8: LSU request fields
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1: LSU response handshake
- `lsu_rdata` out DW: load data; don't-care for stores
- `mem_req_valid` out 1 / `mem_req_ready` in 1: slave request handshake
- `mem_addr` out AW, `mem_wen` out 1, `mem_wdata` out DW, `mem_wmask` out 8: slave request fields
- `mem_resp_valid` in 1 / `mem_resp_ready` out 1: slave response handshake
- `mem_rdata` in DW: slave read data
- `grant` out 2: current owner; 2'b00 none, 2'b01 IFU, 2'b10 LSU

## Operation
- States: IDLE, REQ, RESP. Registers: `state`, `owner`, `last`, and latched `addr`/`wen`/`wdata`/`wmask`.
- IDLE:
  - Winner: if only one master's `*_req_valid` is high, that master wins.
  - If both are high, the master not equal to `last` wins. `last` resets to LSU, so IFU wins the first tie.
  - Winner's `*_req_ready` is 1 combinationally in the same cycle. The loser's ready is 0.
  - On that edge: latch the winner's fields, set `owner`, go to REQ.
  - IFU requests latch `wen=0`, `wmask=0`, `wdata=0`.
- REQ:
  - `mem_req_valid=1`, driving the latched fields.
  - Fields are held stable until `mem_req_ready`; then go to RESP.
- RESP:
  - `mem_resp_ready` = owner's `*_resp_ready`.
  - Owner's `*_resp_valid` = `mem_resp_valid`; owner's `*_rdata` = `mem_rdata` (combinational pass-through).
  - On `mem_resp_valid && mem_resp_ready`: set `last=owner`, clear `owner`, go to IDLE.
- `*_req_ready` is 0 outside IDLE. The non-owner's `*_resp_valid` is always 0.
- `mem_resp_ready` is 0 in IDLE and REQ; `mem_resp_valid` is ignored there.
- Non-owner `*_rdata` reads 0.
- `grant` mirrors `owner`.
- Address alignment and mask legality are not checked; the arbiter passes them through.

## Timing
- Reset (`rst`=0, async, takes effect immediately): state IDLE, `owner`=none, `last`=LSU, latched fields 0. All outputs are 0.
- Reset mid-transaction aborts it with no response delivered. The slave must be reset by the same `rst`.
- Minimum round trip, request accepted at cycle T:
  - `mem_req_valid` rises at T+1.
  - With `mem_req_ready`=1 at T+1 and `mem_resp_valid`=1 at T+2, the owner sees `resp_valid` at T+2.
  - Back in IDLE at T+3; the next accept can happen at T+3.
- A master may drop `*_req_valid` after acceptance with no effect on the transaction.
- A request arriving during REQ/RESP waits; a master holding valid is served in the next IDLE cycle it wins.
- Back-pressure: owner `resp_ready`=0 holds RESP indefinitely, and `mem_resp_ready` stays 0.
- Simultaneous release and new request are handled as follows:
  - The RESP→IDLE edge does not accept a request; acceptance happens in IDLE only.
  - Fairness: continuous requests from both masters alternate IFU, LSU, IFU, ...

## Test plan
- Reset: hold `rst`=0 with random inputs → every output is 0 and `grant`=0. Release, then IFU req addr 0x8000_0000 → `ifu_req_ready`=1 in the same cycle; next cycle `mem_addr`=0x8000_0000, `mem_wen`=0.
- LSU store: `lsu_addr`=0x8000_1004, `wdata`=0xDEAD_BEEF, `wmask`=0x0F, `wen`=1 → the slave sees identical fields. The fields are held across 3 cycles of `mem_req_ready`=0, then `lsu_resp_valid` pulses with the slave response.
- Tie after reset: both valid at cycle 0 → IFU granted. Both stay valid → grants alternate LSU, IFU, LSU over 4 transactions, with `grant`=01,10,01,10.
- Back-pressure: LSU load, `mem_rdata`=0x1234_5678 with `lsu_resp_ready`=0 for 4 cycles → `mem_resp_ready`=0 and state stays RESP. When ready is asserted, `lsu_rdata`=0x1234_5678 and the arbiter returns to IDLE. `ifu_resp_valid` stays 0 throughout.
- Mid-op reset: assert `rst`=0 while in REQ → outputs are 0 immediately. After release, a new IFU request completes normally.
- Stray response: `mem_resp_valid`=1 while in IDLE → no `*_resp_valid` and `mem_resp_ready`=0.
